tone_sequencer: RTL
===================

// Module: tone_sequencer
// PURPOSE
//  Upstream control stage for the clock divider: steps through a fixed melody table and drives
//  count_to (half-period divisor) plus tone_en. Divider output square wave has period
//  2*(count_to+1) CLK_50M cycles. Each step sounds for a NOTE time, then mutes for a GAP time.
//  Sits between board push-buttons/switches and the divider feeding the audio pin.
// PARAMETERS
//  MS_CYCLES   50000  CLK_50M cycles per 1 ms tick (sim: 4)
//  NOTE_MS     250    base note duration in ms ticks (before tempo scaling)
//  GAP_MS      50     silent gap after every step, ms ticks (not tempo-scaled)
//  NUM_STEPS   16     melody table length, 1..16
// PORTS
//  CLK_50M   in   1   system clock, 50 MHz
//  reset     in   1   synchronous, active-high
//  start     in   1   1-cycle pulse: begin playback at step 0 (ignored while busy)
//  stop      in   1   level/pulse: abort playback
//  loop_en   in   1   1 = wrap to step 0 after last step; 0 = finish
//  tempo_sel in   2   note length = NOTE_MS << tempo_sel (1x,2x,4x,8x), sampled at start
//  count_to  out  32  divisor to clock divider
//  tone_en   out  1   1 = audible; divider reset is driven from ~tone_en
//  step_idx  out  4   current table step
//  busy      out  1   high in NOTE or GAP
//  done      out  1   1-cycle pulse when non-looping playback completes
// BEHAVIOUR
//  Reset: state=IDLE, count_to=0, tone_en=0, step_idx=0, busy=0, done=0, ms prescaler=0.
//  Tick: ms prescaler counts 0..MS_CYCLES-1; tick=1 on terminal cycle; prescaler cleared on
//   entry to every state (each step timed from a fresh ms boundary).
//  Table entry = {rest[3], note[2:0]}; note divisors (C4..C5):
//   95553, 85131, 75842, 71584, 63774, 56817, 50618, 47777.
//  FSM:
//   IDLE: outputs idle values. start (and !stop) -> NOTE, step_idx=0, latch tempo_sel.
//   NOTE: count_to=divisor[note]; tone_en=~rest. ms counter counts ticks; when
//    (NOTE_MS<<tempo)-th tick arrives -> GAP.
//   GAP: tone_en=0, count_to held. after GAP_MS ticks: if step_idx<NUM_STEPS-1 -> NOTE,
//    step_idx+1; else if loop_en -> NOTE, step_idx=0; else -> IDLE, done=1 for one cycle.
//  Latency: start registered on cycle N -> count_to/tone_en valid on cycle N+1.
//  Outputs all registered; count_to changes only on NOTE entry.
//  Boundaries:
//   stop has priority over every other event: any state -> IDLE next cycle, tone_en=0,
//    no done pulse; start in same cycle as stop is ignored.
//   start while busy ignored (no restart, tempo not re-latched).
//   loop_en sampled at end of last GAP only; clearing mid-step ends after current pass.
//   tempo_sel changes during playback have no effect.
//   GAP_MS=0: GAP lasts exactly 1 cycle.
//   Reset mid-note: immediate return to reset values on next edge.
// STRUCTURE
//  Shared package: state encoding (IDLE/NOTE/GAP), NOTE_DIV[0:7] divisor constants,
//   melody table contents.
//  Sub-module: ms_tick_gen (MS_CYCLES prescaler with sync clear, tick output).
//  Top: FSM, duration counter (16 bits), step counter, output registers.
// TESTING (MS_CYCLES=4, NOTE_MS=3, GAP_MS=2, NUM_STEPS=4)
//  Reset held 3 cycles -> count_to=0, tone_en=0, busy=0, step_idx=0.
//  start, tempo_sel=0, loop_en=0 -> step0 count_to=95553 tone_en=1 for 12 cycles, gap 8 cycles,
//   steps 1..3 follow; done pulses once; busy falls same cycle.
//  tempo_sel=2 -> note phase 48 cycles; change tempo_sel mid-play -> length unchanged.
//  loop_en=1 -> after step3 gap step_idx=0 again, no done pulse.
//  stop during NOTE of step 2 -> IDLE next cycle, tone_en=0, no done; start next cycle replays.
//  start pulsed while busy and start+stop same cycle -> both ignored; rest entry keeps tone_en=0.

Source files
------------

// File: rtl/tone_sequencer_pkg.sv
// Shared definitions for the tone sequencer: FSM encoding, note divisors and melody table.
// Table entry = {rest, note[2:0]}; divisors are half-period counts for C4..C5 at 50 MHz.
package tone_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_NOTE = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   localparam logic [31:0] NOTE_DIV [0:7] = '{
      32'd95553, 32'd85131, 32'd75842, 32'd71584,
      32'd63774, 32'd56817, 32'd50618, 32'd47777
   };

   localparam logic [3:0] MELODY [0:15] = '{
      4'h0, 4'hA, 4'h4, 4'h7, 4'h0, 4'h2, 4'h4, 4'h5,
      4'h7, 4'hF, 4'h7, 4'h5, 4'h4, 4'h2, 4'h1, 4'h0
   };

   function automatic logic [31:0] step_div(input logic [3:0] entry);
      return NOTE_DIV[entry[2:0]];
   endfunction

endpackage

// File: rtl/tone_sequencer_ms.sv
// Millisecond prescaler: counts 0..MS_CYCLES-1, tick on the terminal count.
// i_clr restarts the count so the caller can time from a fresh ms boundary.
module ms_tick_gen #(
   parameter int MS_CYCLES = 50000
) (
   input  logic CLK_50M,
   input  logic reset,
   input  logic i_clr,
   output logic o_tick
);
   localparam int CW = $clog2(MS_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(MS_CYCLES - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge CLK_50M) begin
      if (reset || i_clr) begin
         r_cnt <= '0;
      end else if (r_cnt == LAST) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/tone_sequencer.sv
// Melody sequencer: steps the table, driving divider count_to and tone_en per NOTE/GAP phase.
// All outputs registered; stop aborts from any state; start is ignored while busy.
module tone_sequencer
   import tone_sequencer_pkg::*;
#(
   parameter int MS_CYCLES = 50000,
   parameter int NOTE_MS   = 250,
   parameter int GAP_MS    = 50,
   parameter int NUM_STEPS = 16
) (
   input  logic        CLK_50M,
   input  logic        reset,
   input  logic        start,
   input  logic        stop,
   input  logic        loop_en,
   input  logic [1:0]  tempo_sel,
   output logic [31:0] count_to,
   output logic        tone_en,
   output logic [3:0]  step_idx,
   output logic        busy,
   output logic        done
);
   localparam logic [15:0] GAP_LAST  = (GAP_MS == 0) ? 16'd0 : 16'(GAP_MS - 1);
   localparam logic [3:0]  LAST_STEP = 4'(NUM_STEPS - 1);

   state_t      r_state, w_nxt_state;
   logic [31:0] r_count, w_nxt_count;
   logic        r_tone, w_nxt_tone;
   logic [3:0]  r_step, w_nxt_step;
   logic        r_done, w_nxt_done;
   logic [1:0]  r_tempo, w_nxt_tempo;
   logic [15:0] r_dur, w_note_last;
   logic        w_tick, w_enter, w_dur_inc, w_load;
   logic [3:0]  w_load_step;

   ms_tick_gen #(.MS_CYCLES(MS_CYCLES)) u_ms_tick (
      .CLK_50M (CLK_50M),
      .reset   (reset),
      .i_clr   (w_enter),
      .o_tick  (w_tick)
   );

   assign w_note_last = (16'(NOTE_MS) << r_tempo) - 16'd1;

   always_ff @(posedge CLK_50M) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_nxt_state;
   end

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_count = r_count;
      w_nxt_tone  = r_tone;
      w_nxt_step  = r_step;
      w_nxt_tempo = r_tempo;
      w_nxt_done  = 1'b0;
      w_enter     = 1'b0;
      w_dur_inc   = 1'b0;
      w_load      = 1'b0;
      w_load_step = '0;
      if (stop) begin
         if (r_state != ST_IDLE) begin
            w_nxt_state = ST_IDLE;
            w_enter     = 1'b1;
            w_nxt_count = '0;
            w_nxt_tone  = 1'b0;
            w_nxt_step  = '0;
         end
      end else begin
         case (r_state)
            ST_IDLE: if (start) begin
               w_nxt_state = ST_NOTE;
               w_nxt_tempo = tempo_sel;
               w_load      = 1'b1;
               w_enter     = 1'b1;
            end
            ST_NOTE: if (w_tick) begin
               if (r_dur == w_note_last) begin
                  w_nxt_state = ST_GAP;
                  w_nxt_tone  = 1'b0;
                  w_enter     = 1'b1;
               end else begin
                  w_dur_inc = 1'b1;
               end
            end
            ST_GAP: begin
               // A zero-length gap still spends its one entry cycle here
               if ((GAP_MS == 0) || (w_tick && r_dur == GAP_LAST)) begin
                  w_enter = 1'b1;
                  if (r_step < LAST_STEP) begin
                     w_nxt_state = ST_NOTE;
                     w_load      = 1'b1;
                     w_load_step = r_step + 4'd1;
                  end else if (loop_en) begin
                     w_nxt_state = ST_NOTE;
                     w_load      = 1'b1;
                  end else begin
                     w_nxt_state = ST_IDLE;
                     w_nxt_done  = 1'b1;
                     w_nxt_count = '0;
                     w_nxt_step  = '0;
                  end
               end else if (w_tick) begin
                  w_dur_inc = 1'b1;
               end
            end
            default: w_nxt_state = ST_IDLE;
         endcase
      end
      if (w_load) begin
         w_nxt_step  = w_load_step;
         w_nxt_count = step_div(MELODY[w_load_step]);
         w_nxt_tone  = ~MELODY[w_load_step][3];
      end
   end

   always_ff @(posedge CLK_50M) begin
      if (reset) begin
         r_count <= '0;
         r_tone  <= 1'b0;
         r_step  <= '0;
         r_done  <= 1'b0;
         r_tempo <= '0;
         r_dur   <= '0;
      end else begin
         r_count <= w_nxt_count;
         r_tone  <= w_nxt_tone;
         r_step  <= w_nxt_step;
         r_done  <= w_nxt_done;
         r_tempo <= w_nxt_tempo;
         if (w_enter)        r_dur <= '0;
         else if (w_dur_inc) r_dur <= r_dur + 16'd1;
      end
   end

   assign count_to = r_count;
   assign tone_en  = r_tone;
   assign step_idx = r_step;
   assign busy     = (r_state != ST_IDLE);
   assign done     = r_done;

endmodule
